// File: rtl/loproc_clk_gate_ctrl.sv
// Clock-gating controller for LoPROC: decides when the core clock is gated
// (software sleep request or idle timeout) and sequences the wake/settle
// window before the core is told the clock is usable again.
module loproc_clk_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic       src_clk,
  input  logic       rst,
  input  logic       busy,
  input  logic       sleep_req,
  input  logic       auto_en,
  input  logic       wake_evt,
  output logic       clk_en,
  output logic       sleep_ack,
  output logic       core_ready,
  output logic       sleeping,
  output logic [1:0] state
);

  localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYCLES);
  localparam logic [WW-1:0] WAKE_LOAD = WW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ARM   = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [WW-1:0] wake_q, wake_d;
  logic          clk_en_q, clk_en_d;
  logic          timeout;

  // Idle timeout qualifies the saturated idle count with the auto-sleep enable
  always_comb begin
    timeout = auto_en && (idle_q == IDLE_MAX);
  end

  // Next-state, wake settle counter, idle counter and clk_en flop input
  always_comb begin
    state_d = state_q;
    wake_d  = wake_q;
    idle_d  = idle_q;

    unique case (state_q)
      ST_RUN: begin
        // wake_evt and busy both outrank a sleep request or timeout
        if (!busy && !wake_evt && (sleep_req || timeout)) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        state_d = (!busy && !wake_evt) ? ST_SLEEP : ST_RUN;
      end
      ST_SLEEP: begin
        if (wake_evt) begin
          state_d = ST_WAKE;
          wake_d  = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (wake_q == '0) begin
          state_d = ST_RUN;
        end else begin
          wake_d = wake_q - WW'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (busy || wake_evt || (state_d == ST_RUN && state_q != ST_RUN)) begin
      idle_d = '0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + IW'(1);
    end

    // clk_en is registered from the next state so it drops exactly on SLEEP entry
    clk_en_d = (state_d != ST_SLEEP);
  end

  // State and counter registers, asynchronously cleared to RUN with clock enabled
  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      idle_q   <= '0;
      wake_q   <= '0;
      clk_en_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      wake_q   <= wake_d;
      clk_en_q <= clk_en_d;
    end
  end

  // Moore outputs decoded from the state register only
  always_comb begin
    state      = state_q;
    clk_en     = clk_en_q;
    sleep_ack  = (state_q == ST_ARM);
    core_ready = (state_q == ST_RUN) || (state_q == ST_ARM);
    sleeping   = (state_q == ST_SLEEP);
  end

endmodule

// File: tb/tb_loproc_clk_gate_ctrl.sv
// Self-checking bench for loproc_clk_gate_ctrl: directed vector table,
// multi-cycle corner sequences, and randomized stimulus against a reference model.
module tb_loproc_clk_gate_ctrl;

  localparam int IDLE = 16;
  localparam int WAKE = 2;

  logic       src_clk;
  logic       rst;
  logic       busy, sleep_req, auto_en, wake_evt;
  logic       clk_en, sleep_ack, core_ready, sleeping;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  loproc_clk_gate_ctrl #(
    .IDLE_CYCLES(IDLE),
    .WAKE_CYCLES(WAKE)
  ) dut (
    .src_clk   (src_clk),
    .rst       (rst),
    .busy      (busy),
    .sleep_req (sleep_req),
    .auto_en   (auto_en),
    .wake_evt  (wake_evt),
    .clk_en    (clk_en),
    .sleep_ack (sleep_ack),
    .core_ready(core_ready),
    .sleeping  (sleeping),
    .state     (state)
  );

  initial src_clk = 1'b0;
  always #5 src_clk = ~src_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // m_st: 0 RUN, 1 ARM, 2 SLEEP, 3 WAKE. Idle run length is kept uncapped,
  // wake time is counted upward as cycles already spent in WAKE.
  int m_st, m_idle, m_wake_age;

  task automatic model_reset();
    m_st = 0; m_idle = 0; m_wake_age = 0;
  endtask

  task automatic model_step(input bit b, input bit sr, input bit ae, input bit we);
    int nst;
    nst = m_st;
    case (m_st)
      0: if (!b && !we && (sr || (ae && m_idle >= IDLE))) nst = 1;
      1: nst = (!b && !we) ? 2 : 0;
      2: if (we) nst = 3;
      default: if (m_wake_age >= WAKE - 1) nst = 0;
    endcase
    if (m_st == 3 && nst == 3) m_wake_age++;
    else m_wake_age = 0;
    if (b || we || (nst == 0 && m_st != 0)) m_idle = 0;
    else m_idle++;
    m_st = nst;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int st, input int ce,
                          input int ack, input int rdy, input int slp);
    chk({tag, " state"},      int'(state),      st);
    chk({tag, " clk_en"},     int'(clk_en),     ce);
    chk({tag, " sleep_ack"},  int'(sleep_ack),  ack);
    chk({tag, " core_ready"}, int'(core_ready), rdy);
    chk({tag, " sleeping"},   int'(sleeping),   slp);
  endtask

  task automatic chk_model(input string tag);
    chk_outs(tag, m_st, (m_st != 2) ? 1 : 0, (m_st == 1) ? 1 : 0,
             (m_st <= 1) ? 1 : 0, (m_st == 2) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge src_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; busy = 1'b0; sleep_req = 1'b0; auto_en = 1'b0; wake_evt = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // Edge 0 samples a "hold" condition (busy, or wake+sleep_req); after it all
  // inputs drop with auto_en=1. Optional busy pulse sampled at pulse_edge.
  task automatic arm_latency(input int pulse_edge, input bit hold_wake,
                             output int arm_edge, output int sleep_edge);
    auto_en = 1'b1;
    if (hold_wake) begin
      wake_evt = 1'b1; sleep_req = 1'b1; busy = 1'b0;
    end else begin
      busy = 1'b1; sleep_req = 1'b0; wake_evt = 1'b0;
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hold_wake) chk("simultaneous wake+sleep_req no ARM", int'(state), 0);
    end
    busy = 1'b0; wake_evt = 1'b0; sleep_req = 1'b0;
    arm_edge = -1; sleep_edge = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == pulse_edge) busy = 1'b1;
      tick();
      busy = 1'b0;
      if (state == 2'd1 && arm_edge < 0) arm_edge = k;
      if (state == 2'd2 && sleep_edge < 0) sleep_edge = k;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int busy, sreq, auto_en, wake;
    int st, ce, ack, rdy, slp;
  } vec_t;

  vec_t tbl[21];
  int   arm_e, sleep_e;

  initial begin
    tbl[0]  = '{1,1,0,0, 0,1,0,1,0};
    tbl[1]  = '{1,1,0,0, 0,1,0,1,0};
    tbl[2]  = '{1,1,0,0, 0,1,0,1,0};
    tbl[3]  = '{0,1,0,0, 1,1,1,1,0};
    tbl[4]  = '{1,1,0,0, 0,1,0,1,0};
    tbl[5]  = '{0,1,0,0, 1,1,1,1,0};
    tbl[6]  = '{0,0,0,0, 2,0,0,0,1};
    tbl[7]  = '{1,1,0,0, 2,0,0,0,1};
    tbl[8]  = '{0,0,0,1, 3,1,0,0,0};
    tbl[9]  = '{0,1,0,1, 3,1,0,0,0};
    tbl[10] = '{0,1,0,0, 0,1,0,1,0};
    tbl[11] = '{0,1,0,1, 0,1,0,1,0};
    tbl[12] = '{0,1,0,0, 1,1,1,1,0};
    tbl[13] = '{0,0,0,1, 0,1,0,1,0};
    tbl[14] = '{0,0,0,0, 0,1,0,1,0};
    tbl[15] = '{0,1,0,0, 1,1,1,1,0};
    tbl[16] = '{0,0,0,0, 2,0,0,0,1};
    tbl[17] = '{0,0,0,0, 2,0,0,0,1};
    tbl[18] = '{0,0,0,1, 3,1,0,0,0};
    tbl[19] = '{0,0,0,0, 3,1,0,0,0};
    tbl[20] = '{0,0,0,0, 0,1,0,1,0};

    // Reset values
    rst = 1'b1; busy = 1'b0; sleep_req = 1'b0; auto_en = 1'b0; wake_evt = 1'b0;
    #13;
    chk_outs("reset", 0, 1, 0, 1, 0);
    @(posedge src_clk);
    #1;
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 21; i++) begin
      busy      = tbl[i].busy[0];
      sleep_req = tbl[i].sreq[0];
      auto_en   = tbl[i].auto_en[0];
      wake_evt  = tbl[i].wake[0];
      tick();
      chk_outs($sformatf("vec%0d", i), tbl[i].st, tbl[i].ce, tbl[i].ack, tbl[i].rdy, tbl[i].slp);
    end

    // Async reset in SLEEP, no clock edge needed
    do_reset();
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    tick();
    chk("pre-reset in SLEEP", int'(state), 2);
    #2;
    rst = 1'b1;
    #1;
    chk_outs("async reset", 0, 1, 0, 1, 0);
    busy = 1'b1;
    @(posedge src_clk);
    #1;
    rst = 1'b0;
    repeat (3) tick();
    chk_outs("post-reset busy", 0, 1, 0, 1, 0);

    // Pending request held off by busy, then sleep and timed wake
    do_reset();
    busy = 1'b1; sleep_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_outs($sformatf("pending%0d", i), 0, 1, 0, 1, 0);
    end
    busy = 1'b0;
    tick();
    chk_outs("pending honoured", 1, 1, 1, 1, 0);
    sleep_req = 1'b0;
    tick();
    chk_outs("pending sleep", 2, 0, 0, 0, 1);
    wake_evt = 1'b1;
    tick();
    chk_outs("wake M", 3, 1, 0, 0, 0);
    wake_evt = 1'b0;
    tick();
    chk_outs("wake M+1", 3, 1, 0, 0, 0);
    tick();
    chk_outs("wake M+2", 0, 1, 0, 1, 0);

    // Auto-sleep latency
    do_reset();
    arm_latency(0, 1'b0, arm_e, sleep_e);
    chk("auto ARM edge", arm_e, IDLE + 1);
    chk("auto SLEEP edge", sleep_e, IDLE + 2);

    do_reset();
    arm_latency(8, 1'b0, arm_e, sleep_e);
    chk("auto restart ARM edge", arm_e, IDLE + 9);
    chk("auto restart SLEEP edge", sleep_e, IDLE + 10);

    // Wake+sleep_req together keeps idle counter at 0
    do_reset();
    arm_latency(0, 1'b1, arm_e, sleep_e);
    chk("idle held by wake ARM edge", arm_e, IDLE + 1);

    // Randomized stimulus against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ((i % 300) < 30) begin
        busy = 1'b0; sleep_req = 1'b0; wake_evt = 1'b0; auto_en = 1'b1;
      end else begin
        busy      = ($urandom_range(0, 9) == 0);
        sleep_req = ($urandom_range(0, 7) == 0);
        wake_evt  = ($urandom_range(0, 11) == 0);
        auto_en   = ($urandom_range(0, 3) != 0);
      end
      model_step(busy, sleep_req, auto_en, wake_evt);
      tick();
      chk_model($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
